line_window_ctrl: RTL
=====================

LINE_WINDOW_CTRL -- requirements
Module: line_window_ctrl

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 1600, giving pixels per line.
REQ-002 SHALL have parameter ADDR_W, default 11, giving the line-buffer address width.
REQ-003 SHALL have parameter DATA_W, default 8, giving the pixel width.
REQ-004 SHALL have port clk  input  1  as the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  as the asynchronous, active-low reset.
REQ-006 SHALL have port s_valid  input  1  to mark a pixel present on s_data this cycle.
REQ-007 SHALL have port s_data  input  DATA_W  as the incoming raster pixel.
REQ-008 SHALL have port s_sof  input  1  to mark the first pixel of a frame; it is qualified by s_valid.
REQ-009 SHALL have port m_valid  output  1  to mark a valid 3-row column on m_row0..2.
REQ-010 SHALL have ports m_row0, m_row1, m_row2  output  DATA_W each, carrying the pixels at the current column for lines n-2, n-1 and n.
REQ-011 SHALL have port m_col  output  ADDR_W  giving the column index of the current m_row outputs.
REQ-012 SHALL have port m_eol  output  1  to mark m_col == LINE_WIDTH-1 while m_valid is high.

Function
REQ-013 SHALL instantiate three line buffers, each with a 1-cycle registered read and a shared addr/we/data_in port.
REQ-014 SHALL drive all three buffers with the same address, the column counter col, in every cycle.
REQ-015 SHALL hold a write-select wsel in {0,1,2}; on an accepted pixel, only buffer wsel is written (we=1, data_in=s_data).
REQ-016 SHALL treat an accepted pixel as s_valid=1 in states FILL0, FILL1 or STREAM, or s_valid=1 with s_sof=1 in any state.
REQ-017 SHALL have state machine states IDLE, FILL0, FILL1 and STREAM; the reset state is IDLE.
REQ-018 SHALL, in IDLE, drop pixels with s_sof=0, with no RAM write and no counter change.
REQ-019 SHALL, on an accepted pixel with s_sof=1 in any state, force col=0, wsel=0 and state FILL0 before processing, so that the pixel is written to buffer 0 at address 0 (restart mid-frame).
REQ-020 SHALL, on an accepted pixel, increment col; at col == LINE_WIDTH-1 it wraps to 0, wsel advances as 0->1->2->0, and state advances FILL0->FILL1->STREAM; STREAM holds.
REQ-021 SHALL, while s_valid=0, hold col, wsel and state and issue no writes.
REQ-022 SHALL assert m_valid exactly 1 cycle after an accepted pixel in STREAM, and deassert it otherwise.
REQ-023 SHALL set m_row2 to that pixel delayed one cycle, m_row1 to the read data of buffer (wsel+2) mod 3, and m_row0 to the read data of buffer (wsel+1) mod 3, using wsel sampled at the accept cycle.
REQ-024 SHALL set m_col to the accept-cycle col delayed one cycle, and m_eol to m_valid AND (m_col == LINE_WIDTH-1).
REQ-025 SHALL perform col arithmetic in ADDR_W bits, with LINE_WIDTH <= 2^ADDR_W.

Reset
REQ-026 SHALL, on rst_n=0, immediately clear state to IDLE, col, wsel, m_valid, m_eol, m_col, m_row0..2 and the delay registers to 0.
REQ-027 SHALL gate buffer we low during reset; RAM contents are not cleared.
REQ-028 SHALL treat reset mid-frame as discarding the frame; output resumes only after a new s_sof and two filled lines.

Structure
REQ-029 SHALL place LINE_WIDTH, ADDR_W, DATA_W defaults and the state encoding in the shared image-pipeline package.
REQ-030 SHALL reuse the existing line_buffer module as the single sub-module, instantiated three times, with no other sub-modules.

Verification
REQ-031 SHALL cover: reset, then pixels with s_sof=0 in IDLE -> no writes, m_valid stays 0.
REQ-032 SHALL cover: frame with pixel value = line index (0,1,2,...) at LINE_WIDTH=1600 -> first m_valid 1 cycle after pixel (line 2, col 0); rows = 0/1/2; at line 3 rows = 1/2/3.
REQ-033 SHALL cover: random s_valid gaps (50% duty) -> output sequence identical to the gap-free run, and col/wsel held during gaps.
REQ-034 SHALL cover: the last pixel of line 4 -> m_eol=1 with m_col=1599; the next output has m_col=0 and wsel rotated.
REQ-035 SHALL cover: s_sof asserted at line 3, col 700 -> state FILL0, col=0, no m_valid until new line 2.
REQ-036 SHALL cover: rst_n pulsed low mid-STREAM -> all outputs 0 in the same cycle, and state IDLE after release.

Source files
------------

// File: rtl/line_window_ctrl_pkg.sv
// Shared image-pipeline definitions: default geometry and the window FSM encoding.
package line_window_ctrl_pkg;

    localparam int LINE_WIDTH_DEF = 1600;
    localparam int ADDR_W_DEF     = 11;
    localparam int DATA_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL0  = 2'd1,
        ST_FILL1  = 2'd2,
        ST_STREAM = 2'd3
    } lw_state_e;

    // (w + k) mod 3 for buffer-select values in {0,1,2}
    function automatic logic [1:0] wsel_add(input logic [1:0] w, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, w} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/line_window_ctrl_line_buffer.sv
// Single-port line buffer: synchronous write, one-cycle registered read (read-first).
module line_buffer #(
    parameter int DEPTH  = 1600,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_window_ctrl.sv
// 3-line vertical window builder: rotates three line buffers and emits one column of
// lines n-2, n-1, n per accepted pixel once two full lines have been stored.
module line_window_ctrl
    import line_window_ctrl_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_row0,
    output logic [DATA_W-1:0] m_row1,
    output logic [DATA_W-1:0] m_row2,
    output logic [ADDR_W-1:0] m_col,
    output logic              m_eol
);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_WIDTH - 1);

    lw_state_e         state_q, state_d, state_eff;
    logic [ADDR_W-1:0] col_q, col_d, col_eff;
    logic [1:0]        wsel_q, wsel_d, wsel_eff;
    logic              accept, restart;

    logic              valid_q, eol_q;
    logic [ADDR_W-1:0] mcol_q;
    logic [DATA_W-1:0] pix_q;
    logic [1:0]        rsel_q;

    logic [DATA_W-1:0] rd [3];
    logic [2:0]        we;

    // An s_sof pixel restarts the frame before it is processed, so it lands at buffer 0, addr 0.
    always_comb begin
        restart   = s_valid && s_sof;
        accept    = s_valid && (s_sof || (state_q != ST_IDLE));
        col_eff   = restart ? '0 : col_q;
        wsel_eff  = restart ? 2'd0 : wsel_q;
        state_eff = restart ? ST_FILL0 : state_q;
        col_d     = col_q;
        wsel_d    = wsel_q;
        state_d   = state_q;
        if (accept) begin
            if (col_eff == COL_LAST) begin
                col_d   = '0;
                wsel_d  = wsel_add(wsel_eff, 2'd1);
                state_d = (state_eff == ST_FILL0) ? ST_FILL1 : ST_STREAM;
            end else begin
                col_d   = col_eff + ADDR_W'(1);
                wsel_d  = wsel_eff;
                state_d = state_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            wsel_q  <= 2'd0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            mcol_q  <= '0;
            pix_q   <= '0;
            rsel_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            wsel_q  <= wsel_d;
            valid_q <= accept && (state_eff == ST_STREAM);
            eol_q   <= accept && (state_eff == ST_STREAM) && (col_eff == COL_LAST);
            if (accept) begin
                mcol_q <= col_eff;
                pix_q  <= s_data;
                rsel_q <= wsel_eff;
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_buf
        assign we[i] = accept && (wsel_eff == 2'(i)) && rst_n;
        line_buffer #(
            .DEPTH  (LINE_WIDTH),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .addr  (col_eff),
            .we    (we[i]),
            .wdata (s_data),
            .rdata (rd[i])
        );
    end

    // Buffer wsel holds line n; the next one round holds n-2, the one after holds n-1.
    always_comb begin
        m_row0 = rd[wsel_add(rsel_q, 2'd1)];
        m_row1 = rd[wsel_add(rsel_q, 2'd2)];
    end

    assign m_row2  = pix_q;
    assign m_valid = valid_q;
    assign m_col   = mcol_q;
    assign m_eol   = eol_q;

endmodule
